// File: rtl/conv_frame_io_pkg.sv
// Shared types and helpers for the convolution frame I/O adapter.
// Holds the FSM state encoding and the counter-width helper.
package conv_frame_io_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_frame_io_out_serializer.sv
// Result buffer and outbound valid/ready stream for the frame adapter.
// Ports: clk, rst (async, active-high); load captures res and starts the
// stream; m_tdata/m_tvalid/m_tlast/m_tready is the outbound handshake;
// done pulses during the handshake of the last word.
module conv_frame_io_out_serializer
    import conv_frame_io_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N*W-1:0] res,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    output logic         m_tlast,
    input  logic         m_tready,
    output logic         done
);

    localparam int OW = cw(N);

    logic [W-1:0]  rbuf [N];
    logic [OW-1:0] oidx;
    logic          valid_q;
    logic          last;

    assign last     = (oidx == OW'(N - 1));
    assign m_tvalid = valid_q;
    assign m_tlast  = valid_q && last;
    // Data is forced to zero when idle so the reset value is visible.
    assign m_tdata  = valid_q ? rbuf[oidx] : '0;
    assign done     = valid_q && m_tready && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rbuf[i] <= '0;
            end
            oidx    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                rbuf[i] <= res[i*W +: W];
            end
            oidx    <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && m_tready) begin
            if (last) begin
                oidx    <= '0;
                valid_q <= 1'b0;
            end else begin
                oidx <= oidx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_frame_io.sv
// Frame I/O adapter around the parallel convolution core: assembles the
// inbound float stream into flat image/kernal buses, waits out the core
// latency, captures res and streams it back out.
// Ports: clk, rst (async, active-high); s_* inbound stream (s_tuser=1 is a
// kernel weight); image/kernal to core; res from core; m_* outbound stream;
// busy is high while waiting on the core or draining results.
module conv_frame_io
    import conv_frame_io_pkg::*;
#(
    parameter int imageWidth  = 5,
    parameter int imageHeight = 5,
    parameter int kernalSize  = 3,
    parameter int wordlength  = 32,
    parameter int convLatency = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic [wordlength-1:0] s_tdata,
    input  logic s_tvalid,
    input  logic s_tuser,
    output logic s_tready,
    output logic [imageWidth*imageHeight*wordlength-1:0] image,
    output logic [kernalSize*kernalSize*wordlength-1:0] kernal,
    input  logic [(imageWidth-kernalSize+1)*(imageHeight-kernalSize+1)*wordlength-1:0] res,
    output logic [wordlength-1:0] m_tdata,
    output logic m_tvalid,
    output logic m_tlast,
    input  logic m_tready,
    output logic busy
);

    localparam int OUT_W = imageWidth - kernalSize + 1;
    localparam int OUT_H = imageHeight - kernalSize + 1;
    localparam int N_IN  = imageWidth * imageHeight;
    localparam int N_K   = kernalSize * kernalSize;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int IW    = cw(N_IN);
    localparam int KW    = cw(N_K);
    localparam int CW    = cw(convLatency + 1);

    state_t state, state_nx;

    logic [wordlength-1:0] img_q [N_IN];
    logic [wordlength-1:0] ker_q [N_K];
    logic [IW-1:0] iidx;
    logic [KW-1:0] kidx;
    logic [CW-1:0] wcnt;

    logic s_acc;
    logic last_pix;
    logic ser_load;
    logic ser_done;

    // Held low during reset so upstream never sees a phantom accept.
    assign s_tready = (state == FILL) && !rst;
    assign s_acc    = s_tvalid && s_tready;
    assign last_pix = s_acc && !s_tuser && (iidx == IW'(N_IN - 1));
    assign ser_load = (state == WAIT) && (wcnt == CW'(1));
    assign busy     = (state != FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:    if (last_pix) state_nx = WAIT;
            WAIT:    if (ser_load) state_nx = DRAIN;
            DRAIN:   if (ser_done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                img_q[i] <= '0;
            end
            for (int i = 0; i < N_K; i++) begin
                ker_q[i] <= '0;
            end
            iidx <= '0;
            kidx <= '0;
            wcnt <= '0;
        end else begin
            if (s_acc && s_tuser) begin
                ker_q[kidx] <= s_tdata;
                kidx <= (kidx == KW'(N_K - 1)) ? '0 : kidx + 1'b1;
            end
            if (s_acc && !s_tuser) begin
                img_q[iidx] <= s_tdata;
                iidx <= last_pix ? '0 : iidx + 1'b1;
            end
            if (last_pix) begin
                wcnt <= CW'(convLatency);
            end else if (state == WAIT) begin
                wcnt <= wcnt - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_img
        assign image[i*wordlength +: wordlength] = img_q[i];
    end

    for (genvar i = 0; i < N_K; i++) begin : g_ker
        assign kernal[i*wordlength +: wordlength] = ker_q[i];
    end

    conv_frame_io_out_serializer #(
        .W (wordlength),
        .N (N_OUT)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .res      (res),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .done     (ser_done)
    );

endmodule

// File: doc/conv_frame_io.md
# conv_frame_io

Frame-level I/O adapter for the parallel convolution IP. It sits on both sides of the convolution core. Inbound, it accepts kernel and image pixels as a 32-bit float stream and assembles them into the flat `image` and `kernal` buses the core consumes. It then holds those buses stable for the core's fixed pipeline latency, captures the flat `res` bus, and streams the result pixels back out with a valid/ready handshake and an end-of-frame marker.

## Interface
Parameters:
- `imageWidth`, 5: input frame width in pixels.
- `imageHeight`, 5: input frame height in pixels.
- `kernalSize`, 3: square kernel edge.
- `wordlength`, 32: pixel/weight width (IEEE-754 single).
- `convLatency`, 40: cycles from a stable `image`/`kernal` until `res` is valid; must be ≥1.

Ports (one clock, `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous active-high reset.
- `s_tdata` in `wordlength`: inbound pixel or weight.
- `s_tvalid` in 1: inbound beat valid.
- `s_tuser` in 1: 1 means the beat is a kernel weight; 0 means an image pixel.
- `s_tready` out 1: the block accepts an inbound beat.
- `image` out `imageWidth*imageHeight*wordlength`: flat image for the core; pixel i is at `[i*wordlength +: wordlength]`.
- `kernal` out `kernalSize²*wordlength`: flat kernel for the core, same packing.
- `res` in `OUT_W*OUT_H*wordlength`: flat result from the core.
- `m_tdata` out `wordlength`: outbound result pixel.
- `m_tvalid` out 1: outbound beat valid.
- `m_tlast` out 1: last result pixel of the frame.
- `m_tready` in 1: downstream accepts.
- `busy` out 1: high in WAIT and DRAIN.

## Operation
- Derived constants:
  - `OUT_W = imageWidth-kernalSize+1`, `OUT_H = imageHeight-kernalSize+1`.
  - `N_IN = imageWidth*imageHeight`, `N_K = kernalSize²`, `N_OUT = OUT_W*OUT_H`.
- The FSM has three states; the reset state is FILL.
  - **FILL:** `s_tready=1`. An accepted beat with `s_tuser=1` writes `kernal[kidx]`; `kidx` increments and wraps from N_K-1 to 0. An accepted beat with `s_tuser=0` writes `image[iidx]`; `iidx` increments. When the beat at `iidx = N_IN-1` is accepted, `iidx` clears, `wcnt` loads `convLatency`, and the FSM moves to WAIT.
  - **WAIT:** `s_tready=0`. `image` and `kernal` are frozen. `wcnt` decrements each cycle. On the cycle `wcnt = 1`, the FSM captures `res` into the output buffer, clears `oidx`, and moves to DRAIN.
  - **DRAIN:** `m_tvalid=1` and `m_tdata = buffer[oidx]`. `m_tlast = (oidx = N_OUT-1)`. On a handshake (`m_tvalid & m_tready`), `oidx` increments. The handshake on the last beat returns the FSM to FILL.
- Kernel weights persist across frames. They may be reloaded at any point in FILL, including interleaved with image pixels; `iidx` is unaffected by kernel beats.
- Output ordering is raster order, row-major, matching the `res` packing (index 0 first).
- No arithmetic is done on the data; words pass through bit-exact.

## Timing
- Reset values:
  - `s_tready=0` while `rst` is asserted, then 1 in FILL.
  - `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `busy=0`.
  - `image=0` and `kernal=0`.
  - All counters are 0.
- A write lands in `image`/`kernal` on the edge that accepts the beat.
- Latency and throughput:
  - From the edge accepting the last image pixel, `res` is sampled exactly `convLatency` edges later.
  - `m_tvalid` rises on the same edge as that sample.
  - With `m_tready` held high, N_OUT beats issue on consecutive cycles.
- Handshake rules:
  - `m_tdata` and `m_tlast` are held stable while `m_tvalid=1` and `m_tready=0`.
  - `s_tready` does not depend on `s_tvalid`.
  - The inbound path accepts at most one beat per cycle.
- Boundary conditions:
  - The cycle after the final output handshake: FILL, `s_tready=1`, `m_tvalid=0`.
  - `s_tvalid=1` during WAIT or DRAIN is ignored; upstream must hold the beat.
  - Kernel-index wrap with 10 kernel beats: beat 10 overwrites weight 0.
  - Reset asserted mid-WAIT or mid-DRAIN: the frame is aborted, all outputs return to reset values immediately, and the FSM restarts in FILL with kernel contents cleared.

## Structure
- Shared include `conv_pkg.vh` holds:
  - the derived constants OUT_W, OUT_H, N_IN, N_K, N_OUT;
  - the state encodings FILL=2'd0, WAIT=2'd1, DRAIN=2'd2.
- Optional sub-module `conv_out_serializer`. It contains the result buffer, `oidx`, and the `m_*` handshake. It takes a one-cycle `load` pulse and emits a `done` pulse on the last handshake.
- Counter widths are `$clog2` of their ranges, minimum 1 bit.

## Test plan
- **Basic frame.** 9 kernel beats of 32'h3F800000, then 25 pixels of values 0..24. Check that `kernal` holds all 1.0, `image[i]=i`, `busy` rises on the edge after pixel 24, and `res` is sampled exactly 40 edges later.
- **Result streaming.** Drive `res` with words 0xA0..0xA8 and hold `m_tready=1`. Expect 9 consecutive beats 0xA0..0xA8, `m_tlast` only on 0xA8, and `s_tready=1` on the following cycle.
- **Backpressure.** Toggle `m_tready` 1,0,0,1,… during DRAIN. Check that `m_tdata`/`m_tlast` are stable through stalls, no beat is duplicated or lost, and the total is 9 beats.
- **Kernel reload and wrap.** Send 10 kernel beats 1..10 interleaved with 5 pixels. Expect `kernal[0]=10`, `kernal[1..8]=2..9`, and `iidx=5`.
- **Input blocking.** Hold `s_tvalid=1` throughout WAIT and DRAIN. Expect `s_tready=0`, `image` unchanged, and no index movement.
- **Reset mid-operation.** Assert `rst` in DRAIN after beat 3. All outputs are reset within the same cycle, the state is FILL, and a new full frame then completes correctly.
